// File: rtl/bus_slot_scheduler.sv
// Shared-bus time-division scheduler: splits each 16-cycle frame into a
// video/SPI slot A (cycles 0-3), an SPI slot B (cycles 4-7) and a CPU phi2
// slot (cycles 8-15). All outputs are registered from next-cycle values so
// that an output "at cycle n" is valid for the whole time cnt == n.
module bus_slot_scheduler #(
    parameter bit VIDEO_EN      = 1'b1,
    parameter bit SPI_DUAL_SLOT = 1'b1
) (
    input  logic clk_16_i,
    input  logic reset_i,
    input  logic spi_valid_i,
    output logic spi_select_o,
    output logic spi_enable_o,
    output logic spi_ready_o,
    input  logic vid_req_i,
    output logic vid_select_o,
    output logic vid_enable_o,
    output logic vid_done_o,
    input  logic cpu_valid_i,
    output logic clk_cpu_o,
    output logic cpu_select_o,
    output logic cpu_enable_o
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_SPI  = 2'd1,
        OWN_VID  = 2'd2
    } owner_t;

    logic [3:0] cnt_reg, cnt_next;
    owner_t     owner_reg, owner_next;
    logic       cpu_grant_reg, cpu_grant_next;

    // Requester channel vectors: index 0 = SPI, index 1 = video.
    logic [1:0] sel_reg, sel_next;
    logic [1:0] en_reg, en_next;
    logic [1:0] pulse_reg, pulse_next;

    logic clk_cpu_reg, clk_cpu_next;
    logic cpu_sel_reg, cpu_sel_next;
    logic cpu_en_reg, cpu_en_next;

    // Frame counter and slot decisions taken at the decision points.
    always_comb begin
        cnt_next       = cnt_reg + 4'd1;
        owner_next     = owner_reg;
        cpu_grant_next = cpu_grant_reg;
        case (cnt_reg)
            4'd15: begin
                if (VIDEO_EN && vid_req_i) begin
                    owner_next = OWN_VID;
                end else if (SPI_DUAL_SLOT && spi_valid_i) begin
                    owner_next = OWN_SPI;
                end else begin
                    owner_next = OWN_IDLE;
                end
            end
            4'd3: begin
                // A valid still visible while slot A's ready pulses is the
                // request that just completed, not a new one.
                if (spi_valid_i && !pulse_reg[0]) begin
                    owner_next = OWN_SPI;
                end else begin
                    owner_next = OWN_IDLE;
                end
            end
            4'd7: begin
                cpu_grant_next = cpu_valid_i;
            end
            default: begin
            end
        endcase
    end

    // Per-requester select / strobe / completion windows inside slots A and B.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            localparam owner_t CHAN_OWNER = (gi == 0) ? OWN_SPI : OWN_VID;
            logic granted;
            assign granted        = !cnt_next[3] && (owner_next == CHAN_OWNER);
            assign sel_next[gi]   = granted;
            assign en_next[gi]    = granted && ((cnt_next[1:0] == 2'd1) || (cnt_next[1:0] == 2'd2));
            assign pulse_next[gi] = granted && (cnt_next[1:0] == 2'd3);
        end
    endgenerate

    // CPU phi2 clock runs regardless of grant; select/strobe follow the cycle-7 sample.
    always_comb begin
        clk_cpu_next = cnt_next[3];
        cpu_sel_next = cnt_next[3] && cpu_grant_next;
        cpu_en_next  = cpu_sel_next && (cnt_next != 4'd8) && (cnt_next != 4'd15);
    end

    // State and output registers; reset aborts any slot without a completion pulse.
    always_ff @(posedge clk_16_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_reg       <= 4'd0;
            owner_reg     <= OWN_IDLE;
            cpu_grant_reg <= 1'b0;
            sel_reg       <= 2'b00;
            en_reg        <= 2'b00;
            pulse_reg     <= 2'b00;
            clk_cpu_reg   <= 1'b0;
            cpu_sel_reg   <= 1'b0;
            cpu_en_reg    <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            owner_reg     <= owner_next;
            cpu_grant_reg <= cpu_grant_next;
            sel_reg       <= sel_next;
            en_reg        <= en_next;
            pulse_reg     <= pulse_next;
            clk_cpu_reg   <= clk_cpu_next;
            cpu_sel_reg   <= cpu_sel_next;
            cpu_en_reg    <= cpu_en_next;
        end
    end

    assign spi_select_o = sel_reg[0];
    assign spi_enable_o = en_reg[0];
    assign spi_ready_o  = pulse_reg[0];
    assign vid_select_o = sel_reg[1];
    assign vid_enable_o = en_reg[1];
    assign vid_done_o   = pulse_reg[1];
    assign clk_cpu_o    = clk_cpu_reg;
    assign cpu_select_o = cpu_sel_reg;
    assign cpu_enable_o = cpu_en_reg;

endmodule

// File: tb/tb_bus_slot_scheduler.sv
// Directed bench for bus_slot_scheduler: drives per-cycle input masks frame by
// frame and compares every output against hand-written per-cycle masks.
module tb_bus_slot_scheduler;

    logic clk_16_i = 1'b0;
    logic reset_i;
    logic spi_valid_i, vid_req_i, cpu_valid_i;

    logic spi_select_a, spi_enable_a, spi_ready_a, vid_select_a, vid_enable_a, vid_done_a;
    logic clk_cpu_a, cpu_select_a, cpu_enable_a;
    logic spi_select_b, spi_enable_b, spi_ready_b, vid_select_b, vid_enable_b, vid_done_b;
    logic clk_cpu_b, cpu_select_b, cpu_enable_b;

    int checks_cnt = 0;
    int errors_cnt = 0;
    logic sel_dut = 1'b0;

    always #5 clk_16_i = ~clk_16_i;

    bus_slot_scheduler dut (
        .clk_16_i(clk_16_i), .reset_i(reset_i),
        .spi_valid_i(spi_valid_i), .spi_select_o(spi_select_a), .spi_enable_o(spi_enable_a),
        .spi_ready_o(spi_ready_a), .vid_req_i(vid_req_i), .vid_select_o(vid_select_a),
        .vid_enable_o(vid_enable_a), .vid_done_o(vid_done_a), .cpu_valid_i(cpu_valid_i),
        .clk_cpu_o(clk_cpu_a), .cpu_select_o(cpu_select_a), .cpu_enable_o(cpu_enable_a)
    );

    bus_slot_scheduler #(.VIDEO_EN(1'b0), .SPI_DUAL_SLOT(1'b0)) dut_min (
        .clk_16_i(clk_16_i), .reset_i(reset_i),
        .spi_valid_i(spi_valid_i), .spi_select_o(spi_select_b), .spi_enable_o(spi_enable_b),
        .spi_ready_o(spi_ready_b), .vid_req_i(vid_req_i), .vid_select_o(vid_select_b),
        .vid_enable_o(vid_enable_b), .vid_done_o(vid_done_b), .cpu_valid_i(cpu_valid_i),
        .clk_cpu_o(clk_cpu_b), .cpu_select_o(cpu_select_b), .cpu_enable_o(cpu_enable_b)
    );

    // Observed vector {clk_cpu, cpu_sel, cpu_en, spi_sel, spi_en, spi_rdy, vid_sel, vid_en, vid_done}
    logic [8:0] obs_vec;
    always_comb begin
        if (sel_dut) begin
            obs_vec = {clk_cpu_b, cpu_select_b, cpu_enable_b, spi_select_b, spi_enable_b,
                       spi_ready_b, vid_select_b, vid_enable_b, vid_done_b};
        end else begin
            obs_vec = {clk_cpu_a, cpu_select_a, cpu_enable_a, spi_select_a, spi_enable_a,
                       spi_ready_a, vid_select_a, vid_enable_a, vid_done_a};
        end
    end

    task automatic check_eq(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %b expected %b", tag, obs, exp);
        end
    endtask

    // Runs ncyc cycles of a frame starting right after the negedge of cycle 0.
    task automatic run_frame(input string tag, input int ncyc,
                             input logic [15:0] spi_v, input logic [15:0] vid_r, input logic [15:0] cpu_v,
                             input logic [15:0] e_ss, input logic [15:0] e_se, input logic [15:0] e_sr,
                             input logic [15:0] e_vs, input logic [15:0] e_ve, input logic [15:0] e_vd,
                             input logic [15:0] e_cs, input logic [15:0] e_ce);
        logic [8:0] exp_vec;
        logic [8:0] sel_vec;
        for (int c = 0; c < ncyc; c++) begin
            spi_valid_i = spi_v[c];
            vid_req_i   = vid_r[c];
            cpu_valid_i = cpu_v[c];
            #1;
            exp_vec = {(c >= 8) ? 1'b1 : 1'b0, e_cs[c], e_ce[c], e_ss[c], e_se[c], e_sr[c],
                       e_vs[c], e_ve[c], e_vd[c]};
            check_eq($sformatf("%s cyc%0d", tag, c), obs_vec, exp_vec);
            sel_vec = {8'd0, ($countones({obs_vec[7], obs_vec[5], obs_vec[2]}) <= 1) &&
                             ($countones({obs_vec[6], obs_vec[4], obs_vec[1]}) <= 1)};
            check_eq($sformatf("%s exclusive cyc%0d", tag, c), sel_vec, 9'd1);
            @(posedge clk_16_i);
            @(negedge clk_16_i);
        end
    endtask

    initial begin
        reset_i = 1'b1;
        spi_valid_i = 1'b0;
        vid_req_i = 1'b0;
        cpu_valid_i = 1'b1;
        repeat (3) @(posedge clk_16_i);
        @(negedge clk_16_i);
        check_eq("reset outputs", obs_vec, 9'd0);
        reset_i = 1'b0;

        // F0: idle bus, CPU running; SPI raised at cycle 15 for slot A next frame
        run_frame("f0_cpu_only", 16, 16'h8000, 16'h0000, 16'hFFFF,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFF00, 16'h7E00);
        // F1: SPI in slot A, valid dropped one cycle after ready -> slot B idle
        run_frame("f1_spi_slot_a", 16, 16'h000F, 16'h0000, 16'hFFFF,
                  16'h000F, 16'h0006, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'hFF00, 16'h7E00);
        // F2: command arrives at cycle 2 -> slot B; both requests raised at cycle 15
        run_frame("f2_spi_slot_b", 16, 16'h80FC, 16'h8000, 16'hFFFF,
                  16'h00F0, 16'h0060, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'hFF00, 16'h7E00);
        // F3: video wins slot A, SPI takes slot B
        run_frame("f3_vid_and_spi", 16, 16'h00FF, 16'h000F, 16'hFFFF,
                  16'h00F0, 16'h0060, 16'h0080, 16'h000F, 16'h0006, 16'h0008, 16'hFF00, 16'h7E00);
        // F4: cpu_valid low at cycle 7, raised at 9 -> no CPU grant, clock still toggles
        run_frame("f4_cpu_denied", 16, 16'h0000, 16'h0000, 16'hFE00,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        // F5: CPU granted again; SPI slot B grant interrupted by reset at cycle 5
        run_frame("f5_before_reset", 5, 16'hFFFC, 16'h0000, 16'hFFFF,
                  16'h00F0, 16'h0060, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'hFF00, 16'h7E00);

        reset_i = 1'b1;
        #1;
        check_eq("midslot reset drop", obs_vec, 9'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_16_i);
            check_eq($sformatf("held reset %0d", i), obs_vec, 9'd0);
        end
        reset_i = 1'b0;

        // F6: still-high SPI valid granted at the first decision point (slot B)
        run_frame("f6_after_reset", 16, 16'h80FF, 16'h8000, 16'hFFFF,
                  16'h00F0, 16'h0060, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'hFF00, 16'h7E00);

        // F7: minimal configuration, slot A never used
        sel_dut = 1'b1;
        run_frame("f7_min_cfg", 16, 16'h00FF, 16'hFFFF, 16'hFFFF,
                  16'h00F0, 16'h0060, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'hFF00, 16'h7E00);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
